// File: rtl/mult_seq_mac.sv
// Iterative shift-add multiply-accumulate unit: one multiplier bit per cycle, LSB first,
// signed/unsigned operands, optional accumulation into the registered result y.
module mult_seq_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  is_signed,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  y,
  output logic                  busy
);

  localparam int PW = 2*DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state;
  logic [PW-1:0]           a_sh;
  logic [PW-1:0]           part;
  logic [DATA_WIDTH-1:0]   b_sh;
  logic [CW-1:0]           count;
  logic                    neg_q, sgn_q, acc_en_q, acc_clr_q;

  logic [DATA_WIDTH-1:0]   a_mag, b_mag;
  logic [PW-1:0]           sum, prod;
  logic [ACC_WIDTH-1:0]    ext, next_y;

  // Magnitudes fit in W unsigned bits, so -2^(W-1) needs no special case.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    a_mag  = a;
    b_mag  = b;
    if (is_signed && a[DATA_WIDTH-1]) a_mag = -a;
    if (is_signed && b[DATA_WIDTH-1]) b_mag = -b;
    sum    = part + (b_sh[0] ? a_sh : '0);
    prod   = neg_q ? -sum : sum;
    ext    = ACC_WIDTH'(prod);
    if (sgn_q) ext = ACC_WIDTH'($signed(prod));
    next_y = ext;
    if (acc_en_q) next_y = (acc_clr_q ? '0 : y) + ext;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      part      <= '0;
      b_sh      <= '0;
      count     <= '0;
      neg_q     <= 1'b0;
      sgn_q     <= 1'b0;
      acc_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
      y         <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh      <= PW'(a_mag);
          b_sh      <= b_mag;
          part      <= '0;
          count     <= '0;
          neg_q     <= is_signed & (a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1]);
          sgn_q     <= is_signed;
          acc_en_q  <= acc_en;
          acc_clr_q <= acc_clr;
          state     <= CALC;
        end
        CALC: begin
          part  <= sum;
          a_sh  <= a_sh << 1;
          b_sh  <= b_sh >> 1;
          count <= count + 1'b1;
          if (count == CW'(DATA_WIDTH-1)) begin
            y     <= next_y;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mult_seq_mac.sv
// Self-checking bench for mult_seq_mac (W=8, ACC_WIDTH=20): arithmetic model of the
// accumulator, a per-cycle compare process, and directed vectors with literal results.
module tb_mult_seq_mac;

  localparam int W  = 8;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, is_signed, acc_en, acc_clr;
  logic          out_valid, out_ready, busy;
  logic [W-1:0]  a, b;
  logic [AW-1:0] y;

  int checks   = 0;
  int failures = 0;
  logic [AW-1:0] exp_y = '0;

  mult_seq_mac #(.DATA_WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: plain integer multiply, optional add of the previous result, modulo 2^AW.
  task automatic model_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input logic sg, input logic en, input logic clr);
    longint pa, pb, p, base, nv;
    pa   = sg ? longint'($signed(ta))  : longint'(ta);
    pb   = sg ? longint'($signed(tbv)) : longint'(tbv);
    p    = pa * pb;
    base = clr ? 64'sd0 : longint'(exp_y);
    nv   = en ? base + p : p;
    exp_y = AW'(nv);
  endtask

  // Compare process: invariants every cycle, result against the model while valid.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("busy_vs_ready", {31'd0, busy}, {31'd0, ~in_ready});
      if (out_valid) check("y_model", 32'(y), 32'(exp_y));
    end
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                       input logic sg, input logic en, input logic clr, input int hold,
                       output logic [AW-1:0] ry, output int lat);
    logic [AW-1:0] snap;
    @(negedge clk);
    a = ta; b = tbv; is_signed = sg; acc_en = en; acc_clr = clr;
    in_valid = 1'b1; out_ready = 1'b0;
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    model_op(ta, tbv, sg, en, clr);
    #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
    is_signed = ~sg; acc_en = ~en; acc_clr = ~clr;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); lat++; #1;
    end
    if (!out_valid) check("done_timeout", 32'd0, 32'd1);
    snap = y;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_y", 32'(y), 32'(snap));
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_ready", {31'd0, in_ready}, 32'd1);
    check("post_hs_valid", {31'd0, out_valid}, 32'd0);
    check("post_hs_y", 32'(y), 32'(snap));
    ry = y;
  endtask

  initial begin
    logic [AW-1:0] r;
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; is_signed = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_y", 32'(y), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Basic products and latency
    do_op(8'd255, 8'd255, 1'b0, 1'b0, 1'b0, 0, r, lat);
    check("u255x255", 32'(r), 32'h0FE01);
    check("latency", 32'(lat), 32'(W));
    do_op(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 0, r, lat);
    check("s_m128xm128", 32'(r), 32'h04000);
    do_op(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 0, r, lat);
    check("s_m1x1", 32'(r), 32'hFFFFF);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 0, r, lat);
    check("u_ffx1", 32'(r), 32'h000FF);
    do_op(8'h85, 8'h13, 1'b1, 1'b0, 1'b0, 0, r, lat);   // -123*19 = -2337
    check("s_m123x19", 32'(r), 32'hFF6DF);

    // Accumulate sequence
    do_op(8'd3, 8'd4, 1'b0, 1'b1, 1'b1, 0, r, lat);
    check("acc_clr", 32'(r), 32'd12);
    do_op(8'd5, 8'd6, 1'b0, 1'b1, 1'b0, 0, r, lat);
    check("acc_add", 32'(r), 32'd42);
    do_op(8'hFE, 8'd3, 1'b1, 1'b1, 1'b0, 0, r, lat);    // 42 + (-6)
    check("acc_signed", 32'(r), 32'd36);
    do_op(8'd2, 8'd2, 1'b0, 1'b0, 1'b0, 0, r, lat);
    check("acc_off", 32'(r), 32'd4);

    // Wrap: 17 accumulations of 255*255
    do_op(8'd255, 8'd255, 1'b0, 1'b1, 1'b1, 0, r, lat);
    for (int i = 0; i < 16; i++) do_op(8'd255, 8'd255, 1'b0, 1'b1, 1'b0, 0, r, lat);
    check("wrap17", 32'(r), 32'h0DE11);

    // Backpressure with toggling inputs while DONE
    do_op(8'd10, 8'd11, 1'b0, 1'b0, 1'b0, 5, r, lat);
    check("bp_result", 32'(r), 32'd110);
    @(posedge clk); #1;
    check("bp_no_extra", {31'd0, busy}, 32'd0);

    // Reset during CALC cycle 4
    @(negedge clk);
    a = 8'd100; b = 8'd77; is_signed = 1'b0; acc_en = 1'b1; acc_clr = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_y", 32'(y), 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    exp_y = '0;
    @(negedge clk); rst_n = 1'b1;
    do_op(8'd7, 8'd9, 1'b0, 1'b1, 1'b0, 0, r, lat);
    check("post_rst_acc", 32'(r), 32'd63);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
